// File: rtl/add_tree_acc.sv
// Pipelined binary adder tree over N lanes feeding a frame accumulator.
// Define ADD_TREE_SAT_EN to clamp every add and report clamps on out_sat.
module add_tree_acc #(
  parameter int WL = 16,
  parameter int N  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*WL-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic [WL-1:0]   out_data,
  output logic            out_valid,
  output logic [7:0]      out_beats,
  output logic            out_sat
);

  localparam int L     = $clog2(N);
  localparam int Lanes = 2 * N - 1;

  // Level k of the tree occupies lanes [2N - 2N>>k, 2N - 2N>>(k+1)) of this vector;
  // level 0 is the raw input, level L is the single final sum.
  logic [Lanes*WL-1:0] w_lvl;
  logic [L:0]          w_lvl_valid;
  logic [L:0]          w_lvl_last;
  logic [L:0]          w_lvl_sat;

  // Returns {clamped, sum}; without saturation the flag is constant 0 and the sum wraps.
  function automatic logic [WL:0] f_add(input logic [WL-1:0] a, input logic [WL-1:0] b);
    logic [WL:0] s;
    logic [WL:0] r;
    s = {a[WL-1], a} + {b[WL-1], b};
    r = {1'b0, s[WL-1:0]};
`ifdef ADD_TREE_SAT_EN
    if (s[WL] != s[WL-1]) begin
      r = s[WL] ? {1'b1, 1'b1, {(WL - 1){1'b0}}} : {1'b1, 1'b0, {(WL - 1){1'b1}}};
    end
`endif
    return r;
  endfunction

  assign w_lvl[N*WL-1:0] = in_data;
  assign w_lvl_valid[0]  = in_valid;
  assign w_lvl_last[0]   = in_valid & in_last;
  assign w_lvl_sat[0]    = 1'b0;

  for (genvar k = 1; k <= L; k++) begin : g_stage
    localparam int InOff  = 2 * N - ((2 * N) >> (k - 1));
    localparam int OutOff = 2 * N - ((2 * N) >> k);
    localparam int Nodes  = N >> k;

    logic [Nodes*WL-1:0] w_sum;
    logic [Nodes-1:0]    w_clamp;
    logic [Nodes*WL-1:0] r_sum;
    logic                r_valid;
    logic                r_last;
    logic                r_sat;

    for (genvar j = 0; j < Nodes; j++) begin : g_node
      logic [WL:0] w_res;
      assign w_res = f_add(w_lvl[(InOff + 2 * j) * WL +: WL],
                           w_lvl[(InOff + 2 * j + 1) * WL +: WL]);
      assign w_sum[j*WL +: WL] = w_res[WL-1:0];
      assign w_clamp[j]        = w_res[WL];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_sat   <= 1'b0;
      end else begin
        r_valid <= w_lvl_valid[k-1];
        r_last  <= w_lvl_last[k-1];
        r_sat   <= w_lvl_sat[k-1] | (|w_clamp);
      end
    end

    // Data registers need no reset: they are only consumed when the valid flag is set.
    always_ff @(posedge clk) begin
      r_sum <= w_sum;
    end

    assign w_lvl[OutOff*WL +: Nodes*WL] = r_sum;
    assign w_lvl_valid[k]               = r_valid;
    assign w_lvl_last[k]                = r_last;
    assign w_lvl_sat[k]                 = r_sat;
  end

  logic [WL-1:0] w_tree;
  logic          w_tree_valid;
  logic          w_tree_last;
  logic          w_tree_sat;
  logic [WL:0]   w_acc_res;
  logic [WL-1:0] w_new_sum;
  logic [7:0]    w_new_beats;
  logic          w_new_sat;

  logic [WL-1:0] r_acc;
  logic [7:0]    r_beats;
  logic          r_acc_sat;
  logic          r_first;
  logic [WL-1:0] r_out_data;
  logic          r_out_valid;
  logic [7:0]    r_out_beats;
  logic          r_out_sat;

  assign w_tree       = w_lvl[(Lanes-1)*WL +: WL];
  assign w_tree_valid = w_lvl_valid[L];
  assign w_tree_last  = w_lvl_last[L];
  assign w_tree_sat   = w_lvl_sat[L];
  assign w_acc_res    = f_add(r_acc, w_tree);

  always_comb begin
    w_new_sum   = w_acc_res[WL-1:0];
    w_new_sat   = w_tree_sat | r_acc_sat | w_acc_res[WL];
    w_new_beats = (r_beats == 8'hFF) ? 8'hFF : r_beats + 8'd1;
    if (r_first) begin
      w_new_sum   = w_tree;
      w_new_sat   = w_tree_sat;
      w_new_beats = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_acc_sat   <= 1'b0;
      r_first     <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_tree_valid) begin
        r_acc     <= w_new_sum;
        r_beats   <= w_new_beats;
        r_acc_sat <= w_new_sat;
        r_first   <= w_tree_last;
        if (w_tree_last) begin
          r_out_data  <= w_new_sum;
          r_out_valid <= 1'b1;
          r_out_beats <= w_new_beats;
          r_out_sat   <= w_new_sat;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_beats = r_out_beats;
  // Without saturation every clamp flag is constant 0, so this folds to a tie-off.
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_add_tree_acc.sv
// Directed bench for add_tree_acc: table of frames plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_add_tree_acc;
  localparam int WL = 16;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*WL-1:0] in_data;
  logic            in_valid;
  logic            in_last;
  logic [WL-1:0]   out_data;
  logic            out_valid;
  logic [7:0]      out_beats;
  logic            out_sat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_tree_acc #(.WL(WL), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  typedef struct {
    logic [WL-1:0] base;
    logic [WL-1:0] step;
    int            beats;
    logic [WL-1:0] exp_data;
    logic [7:0]    exp_beats;
    logic          exp_sat;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N*WL-1:0] lanes(input logic [WL-1:0] base, input logic [WL-1:0] step);
    logic [N*WL-1:0] v;
    logic [WL-1:0]   x;
    x = base;
    for (int i = 0; i < N; i++) begin
      v[i*WL +: WL] = x;
      x = x + step;
    end
    return v;
  endfunction

  task automatic drive_beat(input logic [N*WL-1:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Ticks until out_valid, starting from 'elapsed' edges after the last beat.
  task automatic wait_pulse(input int elapsed, output int lat);
    int n;
    lat = -1;
    n   = elapsed;
    while (n < 20) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic check_pulse(input string tag, input int lat, input logic [WL-1:0] exp_data,
                             input logic [7:0] exp_beats, input logic exp_sat);
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got no out_valid, want pulse after 5 cycles", tag);
    end else begin
      check($sformatf("%s latency", tag), lat, 5);
      check($sformatf("%s data", tag), out_data, exp_data);
      check($sformatf("%s beats", tag), out_beats, exp_beats);
      check($sformatf("%s sat", tag), out_sat, exp_sat);
      tick();
      check($sformatf("%s pulse width", tag), out_valid, 0);
      check($sformatf("%s data hold", tag), out_data, exp_data);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic early;

    tbl[0] = '{16'h0001, 16'h0000, 1,   16'h0010, 8'd1,   1'b0};
    tbl[1] = '{16'h0100, 16'h0000, 3,   16'h3000, 8'd3,   1'b0};
`ifdef ADD_TREE_SAT_EN
    tbl[2] = '{16'h7FFF, 16'h0000, 1,   16'h7FFF, 8'd1,   1'b1};
    tbl[5] = '{16'h8000, 16'h0000, 1,   16'h8000, 8'd1,   1'b1};
`else
    tbl[2] = '{16'h7FFF, 16'h0000, 1,   16'hFFF0, 8'd1,   1'b0};
    tbl[5] = '{16'h8000, 16'h0000, 1,   16'h0000, 8'd1,   1'b0};
`endif
    tbl[3] = '{16'h0001, 16'h0001, 1,   16'h0088, 8'd1,   1'b0};
    tbl[4] = '{16'hFFF8, 16'h0001, 1,   16'hFFF8, 8'd1,   1'b0};
    tbl[6] = '{16'h0002, 16'h0000, 4,   16'h0080, 8'd4,   1'b0};
    tbl[7] = '{16'h0001, 16'h0000, 300, 16'h12C0, 8'd255, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    tick();
    tick();
    check("reset out_data", out_data, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_beats", out_beats, 0);
    check("reset out_sat", out_sat, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      early = 1'b0;
      for (int b = 0; b < tbl[v].beats; b++) begin
        drive_beat(lanes(tbl[v].base, tbl[v].step), b == tbl[v].beats - 1);
        if (b != tbl[v].beats - 1 && out_valid) early = 1'b1;
      end
      check($sformatf("vec%0d early pulse", v), early, 0);
      wait_pulse(1, lat);
      check_pulse($sformatf("vec%0d", v), lat, tbl[v].exp_data, tbl[v].exp_beats, tbl[v].exp_sat);
    end

    // Two beats separated by three bubbles; only the second carries last.
    drive_beat(lanes(16'hFFFF, 16'h0000), 1'b0);
    tick();
    tick();
    tick();
    drive_beat(lanes(16'hFFFF, 16'h0000), 1'b1);
    wait_pulse(1, lat);
    check_pulse("bubble frame", lat, 16'hFFE0, 8'd2, 1'b0);

    // Reset mid-frame discards the partial frame and in-flight beats.
    drive_beat(lanes(16'h0005, 16'h0000), 1'b0);
    drive_beat(lanes(16'h0005, 16'h0000), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst out_data", out_data, 0);
    check("midrst out_beats", out_beats, 0);
    check("midrst out_valid", out_valid, 0);
    drive_beat(lanes(16'h0002, 16'h0000), 1'b1);
    wait_pulse(1, lat);
    check_pulse("after reset", lat, 16'h0020, 8'd1, 1'b0);

    // Back-to-back one-beat frames give pulses on consecutive cycles.
    drive_beat(lanes(16'h0001, 16'h0000), 1'b1);
    drive_beat(lanes(16'h0002, 16'h0000), 1'b1);
    tick();
    check("b2b no pulse at 3", out_valid, 0);
    tick();
    check("b2b no pulse at 4", out_valid, 0);
    tick();
    check("b2b first valid", out_valid, 1);
    check("b2b first data", out_data, 16'h0010);
    check("b2b first beats", out_beats, 8'd1);
    tick();
    check("b2b second valid", out_valid, 1);
    check("b2b second data", out_data, 16'h0020);
    check("b2b second beats", out_beats, 8'd1);
    tick();
    check("b2b pulse end", out_valid, 0);
    check("b2b data hold", out_data, 16'h0020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
